// File: rtl/mac_feeder_if.sv
// Handshake bundle tying mac_feeder to its operand buffers, the MAC and the result sink.
// The master modport is the environment side; the slave modport is the feeder itself.
interface mac_feeder_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 9
);
    logic          start;
    logic [CW-1:0] klen;
    logic          busy;
    logic          done;
    logic [DW-1:0] src_data;
    logic [DW-1:0] src_weight;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] mac_data;
    logic [DW-1:0] mac_weight;
    logic          mac_valid;
    logic          mac_ready;
    logic [DW-1:0] mac_result;
    logic          mac_done;
    logic [DW-1:0] out_result;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output start, klen, src_data, src_weight, src_valid, mac_ready, mac_result, mac_done,
               out_ready,
        input  busy, done, src_ready, mac_data, mac_weight, mac_valid, out_result, out_valid
    );

    modport slave (
        input  start, klen, src_data, src_weight, src_valid, mac_ready, mac_result, mac_done,
               out_ready,
        output busy, done, src_ready, mac_data, mac_weight, mac_valid, out_result, out_valid
    );
endinterface

// File: rtl/mac_feeder.sv
// Feeds klen operand pairs through a 2-entry FIFO into a MAC, then waits for the MAC result
// and hands it downstream on a valid/ready port.
module mac_feeder #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 9
) (
    input logic         clk,
    input logic         rst,
    mac_feeder_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOutput} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] kl_q, pull_cnt_q, issue_cnt_q;
    logic [DW-1:0] fifo_data_q   [2];
    logic [DW-1:0] fifo_weight_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;
    logic [DW-1:0] out_result_q;
    logic          done_q;

    logic start_ok, push, pop, src_ready, mac_valid;

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        src_ready = 1'b0;
        mac_valid = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start && (bus.klen != '0)) begin
                    start_ok = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                // Full FIFO blocks the source even if a pop is pending this cycle.
                src_ready = (count_q != 2'd2) && (pull_cnt_q < kl_q);
                mac_valid = (count_q != 2'd0);
                push      = bus.src_valid && src_ready;
                pop       = mac_valid && bus.mac_ready;
                if (pop && ((issue_cnt_q + CW'(1)) == kl_q)) state_d = StDrain;
            end
            StDrain: begin
                if (bus.mac_done) state_d = StOutput;
            end
            StOutput: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            kl_q         <= '0;
            pull_cnt_q   <= '0;
            issue_cnt_q  <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            out_result_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StOutput) && bus.out_ready;
            if (start_ok) begin
                kl_q        <= bus.klen;
                pull_cnt_q  <= '0;
                issue_cnt_q <= '0;
            end
            if (push) begin
                pull_cnt_q <= pull_cnt_q + CW'(1);
                wr_ptr_q   <= ~wr_ptr_q;
            end
            if (pop) begin
                issue_cnt_q <= issue_cnt_q + CW'(1);
                rd_ptr_q    <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if ((state_q == StDrain) && bus.mac_done) out_result_q <= bus.mac_result;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q]   <= bus.src_data;
            fifo_weight_q[wr_ptr_q] <= bus.src_weight;
        end
    end

    assign bus.src_ready  = src_ready;
    assign bus.mac_valid  = mac_valid;
    assign bus.mac_data   = fifo_data_q[rd_ptr_q];
    assign bus.mac_weight = fifo_weight_q[rd_ptr_q];
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_valid  = (state_q == StOutput);
    assign bus.out_result = out_result_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_mac_feeder.sv
// Directed self-checking bench for mac_feeder: one task per scenario, hand-computed expectations.
module tb_mac_feeder;
    localparam int DW = 16;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_feeder_if #(.DW(DW), .CW(CW)) bus ();
    mac_feeder #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] src_d [8];
    logic [DW-1:0] src_w [8];
    logic [DW-1:0] pop_d [8];
    logic [DW-1:0] pop_w [8];
    int            pop_at [8];
    logic          sr_trace [16];
    logic          mv_trace [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.klen = '0; bus.src_data = '0; bus.src_weight = '0;
        bus.src_valid = 1'b0; bus.mac_ready = 1'b0; bus.mac_result = '0; bus.mac_done = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Sample k is taken 1 time unit after the edge; k=1 is the first ISSUE cycle.
    task automatic pump(input int n_src, input int target, input bit toggle, output int pops);
        int  idx;
        bit  push, pop;
        idx  = 0;
        pops = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.src_valid  = (idx < n_src);
            bus.src_data   = src_d[idx % 8];
            bus.src_weight = src_w[idx % 8];
            bus.mac_ready  = toggle ? (k % 2 == 1) : 1'b1;
            if (k < 16) begin
                sr_trace[k] = bus.src_ready;
                mv_trace[k] = bus.mac_valid;
            end
            push = bus.src_valid && bus.src_ready;
            pop  = bus.mac_valid && bus.mac_ready;
            if (pop && pops < 8) begin
                pop_d[pops]  = bus.mac_data;
                pop_w[pops]  = bus.mac_weight;
                pop_at[pops] = k;
            end
            tick();
            if (push) idx++;
            if (pop) pops++;
            if (pops == target) break;
        end
        bus.src_valid = 1'b0;
        bus.mac_ready = 1'b0;
    endtask

    task automatic drain(input logic [DW-1:0] res);
        bus.mac_done = 1'b1; bus.mac_result = res;
        tick();
        bus.mac_done = 1'b0; bus.mac_result = 16'hFFFF;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.src_ready, bus.mac_valid, bus.out_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.busy, bus.done, bus.src_ready, bus.mac_valid, bus.out_valid});
        end
        checks++;
        if (bus.out_result !== 16'h0000) begin
            failures++; $display("FAIL reset_result: got %h expected 0000", bus.out_result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int pops;
        for (int i = 0; i < 4; i++) begin
            src_d[i] = 16'h0101 * 16'(i + 1);
            src_w[i] = 16'h1000 + 16'(i + 1);
        end
        bus.start = 1'b1; bus.klen = CW'(4);
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL basic_busy: got %b expected 1", bus.busy);
        end
        pump(4, 4, 1'b0, pops);
        checks++;
        if (pops != 4) begin failures++; $display("FAIL basic_pops: got %0d expected 4", pops); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_at[i] != i + 2 || pop_d[i] !== src_d[i] || pop_w[i] !== src_w[i]) begin
                failures++;
                $display("FAIL basic_pop%0d: got cyc %0d %h/%h expected cyc %0d %h/%h", i,
                         pop_at[i], pop_d[i], pop_w[i], i + 2, src_d[i], src_w[i]);
            end
        end
        checks++;
        if ({bus.busy, bus.mac_valid, bus.out_valid} !== 3'b100) begin
            failures++; $display("FAIL basic_drain: got %b expected 100",
                                 {bus.busy, bus.mac_valid, bus.out_valid});
        end
        drain(16'h3C00);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3C00 || bus.done !== 1'b0) begin
            failures++; $display("FAIL basic_output: got v=%b r=%h d=%b expected v=1 r=3c00 d=0",
                                 bus.out_valid, bus.out_result, bus.done);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3C00) begin
            failures++; $display("FAIL basic_hold: got v=%b r=%h expected v=1 r=3c00",
                                 bus.out_valid, bus.out_result);
        end
        release_out();
        checks++;
        if ({bus.out_valid, bus.done, bus.busy} !== 3'b010) begin
            failures++; $display("FAIL basic_done: got %b expected 010",
                                 {bus.out_valid, bus.done, bus.busy});
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL basic_done_once: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_toggle();
        int   pops;
        logic exp_sr [8];
        logic exp_mv [8];
        exp_sr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_mv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            src_d[i] = 16'hA001 + 16'(i);
            src_w[i] = 16'hB001 + 16'(i);
        end
        bus.start = 1'b1; bus.klen = CW'(3);
        tick();
        bus.start = 1'b0;
        pump(3, 3, 1'b1, pops);
        checks++;
        if (pops != 3) begin failures++; $display("FAIL toggle_pops: got %0d expected 3", pops); end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (sr_trace[k] !== exp_sr[k] || mv_trace[k] !== exp_mv[k]) begin
                failures++; $display("FAIL toggle_cyc%0d: got sr=%b mv=%b expected sr=%b mv=%b",
                                     k, sr_trace[k], mv_trace[k], exp_sr[k], exp_mv[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_d[i] !== src_d[i] || pop_w[i] !== src_w[i]) begin
                failures++; $display("FAIL toggle_order%0d: got %h/%h expected %h/%h", i,
                                     pop_d[i], pop_w[i], src_d[i], src_w[i]);
            end
        end
        checks++;
        if ({bus.src_ready, bus.mac_valid, bus.busy} !== 3'b001) begin
            failures++; $display("FAIL toggle_drain: got %b expected 001",
                                 {bus.src_ready, bus.mac_valid, bus.busy});
        end
        drain(16'h0003);
        release_out();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL toggle_done: got %b expected 1", bus.done);
        end
        tick();
    endtask

    task automatic test_klen_zero();
        bus.start = 1'b1; bus.klen = '0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.busy, bus.src_ready, bus.done} !== 3'b000) begin
                failures++; $display("FAIL klen0_cyc%0d: got %b expected 000", i,
                                     {bus.busy, bus.src_ready, bus.done});
            end
            tick();
        end
    endtask

    task automatic test_ignored();
        int pops;
        for (int i = 0; i < 3; i++) begin
            src_d[i] = 16'hC000 + 16'(i);
            src_w[i] = 16'hD000 + 16'(i);
        end
        bus.start = 1'b1; bus.klen = CW'(3);
        tick();
        // start and mac_done during ISSUE must both be ignored.
        bus.start = 1'b1; bus.klen = CW'(1); bus.mac_done = 1'b1; bus.mac_result = 16'hDEAD;
        tick();
        bus.start = 1'b0; bus.mac_done = 1'b0;
        pump(3, 3, 1'b0, pops);
        checks++;
        if (pops != 3) begin failures++; $display("FAIL ign_klen: got %0d pops expected 3", pops); end
        checks++;
        if (pop_d[2] !== 16'hC002) begin
            failures++; $display("FAIL ign_last: got %h expected c002", pop_d[2]);
        end
        tick();
        checks++;
        if ({bus.busy, bus.out_valid} !== 2'b10) begin
            failures++; $display("FAIL ign_wait: got %b expected 10", {bus.busy, bus.out_valid});
        end
        drain(16'h1234);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h1234) begin
            failures++; $display("FAIL ign_capture: got v=%b r=%h expected v=1 r=1234",
                                 bus.out_valid, bus.out_result);
        end
        bus.start = 1'b1; bus.klen = CW'(5);
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h1234 || bus.src_ready !== 1'b0) begin
            failures++; $display("FAIL ign_output: got v=%b r=%h sr=%b expected v=1 r=1234 sr=0",
                                 bus.out_valid, bus.out_result, bus.src_ready);
        end
        release_out();
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            failures++; $display("FAIL ign_done: got %b expected 10", {bus.done, bus.busy});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int pops;
        for (int i = 0; i < 5; i++) begin
            src_d[i] = 16'hE000 + 16'(i);
            src_w[i] = 16'hF000 + 16'(i);
        end
        bus.start = 1'b1; bus.klen = CW'(5);
        tick();
        bus.start = 1'b0;
        pump(5, 2, 1'b0, pops);
        checks++;
        if (pops != 2) begin failures++; $display("FAIL mid_pops: got %0d expected 2", pops); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.src_ready, bus.mac_valid, bus.out_valid} !== 5'b0) begin
            failures++; $display("FAIL mid_reset: got %b expected 00000",
                                 {bus.busy, bus.done, bus.src_ready, bus.mac_valid, bus.out_valid});
        end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++; $display("FAIL mid_nodone: got %b expected 00", {bus.busy, bus.done});
        end
        src_d[0] = 16'h5555; src_w[0] = 16'h7777;
        src_d[1] = 16'h6666; src_w[1] = 16'h8888;
        bus.start = 1'b1; bus.klen = CW'(2);
        tick();
        bus.start = 1'b0;
        pump(2, 2, 1'b0, pops);
        checks++;
        if (pops != 2 || pop_d[0] !== 16'h5555 || pop_w[1] !== 16'h8888) begin
            failures++; $display("FAIL mid_restart: got %0d pops %h/%h expected 2 pops 5555/8888",
                                 pops, pop_d[0], pop_w[1]);
        end
        drain(16'h0042);
        checks++;
        if (bus.out_result !== 16'h0042) begin
            failures++; $display("FAIL mid_result: got %h expected 0042", bus.out_result);
        end
        release_out();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL mid_done: got %b expected 1", bus.done);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_toggle();
        test_klen_zero();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
